// File: rtl/adc_result_buffer.sv
// ADC result capture with optional 2^osr decimation and a show-ahead output FIFO.
// Each finished conversion is added to an accumulator; completed blocks are left-aligned and queued.
module adc_result_buffer #(
  parameter int DATA_BITS    = 12,
  parameter int OSR_LOG2_MAX = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              conv_finished_in,
  input  logic [DATA_BITS-1:0]              result_in,
  input  logic [2:0]                        osr_in,
  output logic [DATA_BITS+OSR_LOG2_MAX-1:0] data_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level_out,
  output logic                              overflow_out,
  input  logic                              clear_overflow_in
);

  localparam int OW = DATA_BITS + OSR_LOG2_MAX;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (OSR_LOG2_MAX > 0) ? OSR_LOG2_MAX : 1;

  logic          conv_finished_q;
  logic [CW-1:0] count;
  logic [2:0]    osr_q;
  logic [OW-1:0] sum;
  logic [OW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level;
  logic          overflow;

  logic          cap, push, pop, full, write, drop;
  logic [2:0]    osr_clamped, osr_cur;
  logic [CW-1:0] count_last;
  logic [OW-1:0] sum_next, push_word;

  // NOTE: every signal gets a default at the top of always_comb so no path can leave it
  // unassigned; a missing branch would otherwise infer a latch.
  always_comb begin
    cap         = conv_finished_in & ~conv_finished_q;
    osr_clamped = (osr_in > 3'(OSR_LOG2_MAX)) ? 3'(OSR_LOG2_MAX) : osr_in;
    // The block's ratio is frozen once its first sample arrives.
    osr_cur     = (count == '0) ? osr_clamped : osr_q;
    sum_next    = ((count == '0) ? '0 : sum) + OW'(result_in);
    count_last  = CW'((32'd1 << osr_cur) - 32'd1);
    push        = cap && (count == count_last);
    push_word   = sum_next << (3'(OSR_LOG2_MAX) - osr_cur);
    full        = (level == LW'(FIFO_DEPTH));
    valid_out   = (level != '0);
    pop         = valid_out & ready_in;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    write       = push & (~full | pop);
    drop        = push & full & ~pop;
  end

  assign data_out       = valid_out ? mem[rd_ptr] : '0;
  assign fifo_level_out = level;
  assign overflow_out   = overflow;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_finished_q <= 1'b1;
      count           <= '0;
      osr_q           <= '0;
      sum             <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      level           <= '0;
      overflow        <= 1'b0;
    end else begin
      conv_finished_q <= conv_finished_in;
      if (cap) begin
        sum   <= sum_next;
        count <= push ? '0 : count + CW'(1);
        if (count == '0) osr_q <= osr_clamped;
      end
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(write) - LW'(pop);
      if (drop)                   overflow <= 1'b1;
      else if (clear_overflow_in) overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; the level counter alone decides which
  // entries are meaningful, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= push_word;
  end

endmodule
